// File: rtl/uart_pkt_pkg.sv
// uart_pkt_pkg: shared sync byte, parser state encoding and checksum helper
package uart_pkt_pkg;
  localparam logic [7:0] SYNC_BYTE = 8'hA5;
  typedef enum logic [2:0] {S_IDLE, S_LEN, S_PAYLOAD, S_CHECK, S_EMIT} state_e;
  function automatic logic [7:0] chk_add(input logic [7:0] sum, input logic [7:0] b);
    return sum + b;
  endfunction
endpackage

// File: rtl/uart_pkt_buffer.sv
// uart_pkt_buffer: DEPTH x 8 payload store, one sync write port (we_i/waddr_i/wdata_i), one async read port (raddr_i/rdata_o)
module uart_pkt_buffer #(
  parameter int DEPTH = 16,
  parameter int AW = 4
) (
  input  logic          clk,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [7:0]    wdata_i,
  input  logic [AW-1:0] raddr_i,
  output logic [7:0]    rdata_o
);
  logic [7:0] mem_q [DEPTH];
  always_ff @(posedge clk) if (we_i) mem_q[waddr_i] <= wdata_i;
  assign rdata_o = mem_q[raddr_i];
endmodule

// File: rtl/uart_pkt_controller.sv
// uart_pkt_controller: parses SYNC/LEN/payload/CHK frames from rx_* and emits the payload on a valid/ready stream (pkt_*), with err_* pulses; optional inter-byte timeout via UART_PKT_TIMEOUT_EN
module uart_pkt_controller
  import uart_pkt_pkg::*;
#(
  parameter int CLOCK_FREQ = 12000000,
  parameter int BAUD_RATE = 9600,
  parameter int MAX_LEN = 16,
  parameter int TIMEOUT_BITS = 20
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] rx_data,
  input  logic       rx_valid,
  output logic [7:0] pkt_data,
  output logic       pkt_valid,
  input  logic       pkt_ready,
  output logic       pkt_last,
  output logic [7:0] pkt_len,
  output logic       err_checksum,
  output logic       err_length,
  output logic       err_overrun,
  output logic       err_timeout
);
  localparam int AW = MAX_LEN > 1 ? $clog2(MAX_LEN) : 1;
  localparam logic [31:0] TO_CYC = 32'(TIMEOUT_BITS * CLOCK_FREQ / BAUD_RATE);
  state_e state_q, state_d;
  logic [7:0] len_q, idx_q, sum_q, rd_data;
  logic len_bad, idx_last, chk_ok, xfer, tmo_hit;
  assign idx_last = idx_q == len_q - 8'd1;
  assign len_bad = rx_data == 8'd0 || rx_data > 8'(MAX_LEN);
  assign chk_ok = rx_data == sum_q;
  assign xfer = state_q == S_EMIT && pkt_ready;
`ifdef UART_PKT_TIMEOUT_EN
  logic [31:0] tmo_q;
  logic parsing;
  assign parsing = state_q == S_LEN || state_q == S_PAYLOAD || state_q == S_CHECK;
  assign tmo_hit = parsing && !rx_valid && tmo_q >= TO_CYC - 32'd1;
  always_ff @(posedge clk)
    if (reset || rx_valid || !parsing || tmo_hit) tmo_q <= '0;
    else tmo_q <= tmo_q + 32'd1;
`else
  assign tmo_hit = 1'b0 & |TO_CYC;
`endif
  always_ff @(posedge clk)
    if (reset) state_q <= S_IDLE;
    else state_q <= state_d;
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:    if (rx_valid && rx_data == SYNC_BYTE) state_d = S_LEN;
      S_LEN:     if (rx_valid) state_d = len_bad ? S_IDLE : S_PAYLOAD;
      S_PAYLOAD: if (rx_valid && idx_last) state_d = S_CHECK;
      S_CHECK:   if (rx_valid) state_d = chk_ok ? S_EMIT : S_IDLE;
      S_EMIT:    if (xfer && idx_last) state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase
    if (tmo_hit) state_d = S_IDLE;
  end
  always_comb begin
    pkt_valid = !reset && state_q == S_EMIT;
    pkt_last = pkt_valid && idx_last;
    pkt_data = pkt_valid ? rd_data : 8'd0;
    pkt_len = reset ? 8'd0 : len_q;
    err_length = !reset && state_q == S_LEN && rx_valid && len_bad;
    err_checksum = !reset && state_q == S_CHECK && rx_valid && !chk_ok;
    err_overrun = !reset && state_q == S_EMIT && rx_valid;
    err_timeout = !reset && tmo_hit;
  end
  // The same index writes payload bytes, then rewinds to 0 to read them back out.
  always_ff @(posedge clk)
    if (reset) begin
      len_q <= 8'd0;
      idx_q <= 8'd0;
      sum_q <= 8'd0;
    end else begin
      if (state_q == S_LEN && rx_valid && !len_bad) begin
        len_q <= rx_data;
        sum_q <= chk_add(8'd0, rx_data);
        idx_q <= 8'd0;
      end
      if (state_q == S_PAYLOAD && rx_valid) begin
        sum_q <= chk_add(sum_q, rx_data);
        idx_q <= idx_last ? 8'd0 : idx_q + 8'd1;
      end
      if (xfer) idx_q <= idx_last ? 8'd0 : idx_q + 8'd1;
    end
  uart_pkt_buffer #(.DEPTH(MAX_LEN), .AW(AW)) u_buf (
    .clk(clk),
    .we_i(state_q == S_PAYLOAD && rx_valid),
    .waddr_i(idx_q[AW-1:0]),
    .wdata_i(rx_data),
    .raddr_i(idx_q[AW-1:0]),
    .rdata_o(rd_data)
  );
endmodule

// File: tb/tb_uart_pkt_controller.sv
// tb_uart_pkt_controller: scoreboard bench for uart_pkt_controller
module tb_uart_pkt_controller;
  logic clk = 0, reset = 1, rx_valid = 0, pkt_ready = 1;
  logic [7:0] rx_data = 0, pkt_data, pkt_len;
  logic pkt_valid, pkt_last, err_checksum, err_length, err_overrun, err_timeout;
  int checks = 0, passes = 0;
  int n_chk = 0, n_len = 0, n_ovr = 0, n_to = 0, n_valid = 0;
  logic [16:0] sb[$];
  logic [16:0] e;
  always #5 clk = ~clk;
  uart_pkt_controller #(.CLOCK_FREQ(4), .BAUD_RATE(1), .MAX_LEN(16), .TIMEOUT_BITS(20)) dut (
    .clk(clk), .reset(reset), .rx_data(rx_data), .rx_valid(rx_valid),
    .pkt_data(pkt_data), .pkt_valid(pkt_valid), .pkt_ready(pkt_ready), .pkt_last(pkt_last),
    .pkt_len(pkt_len), .err_checksum(err_checksum), .err_length(err_length),
    .err_overrun(err_overrun), .err_timeout(err_timeout));
  always @(negedge clk) if (!reset) begin
    if (err_checksum) n_chk++;
    if (err_length) n_len++;
    if (err_overrun) n_ovr++;
    if (err_timeout) n_to++;
    if (pkt_valid) n_valid++;
    if (pkt_valid && pkt_ready) begin
      checks++;
      if (sb.size() == 0) $display("FAIL unexpected_byte got last/len/data=%h expected none", {pkt_last, pkt_len, pkt_data});
      else begin
        e = sb.pop_front();
        if ({pkt_last, pkt_len, pkt_data} !== e) $display("FAIL pkt_byte got last/len/data=%h expected %h", {pkt_last, pkt_len, pkt_data}, e);
        else passes++;
      end
    end
  end
  task automatic step();
    @(posedge clk); #1;
  endtask
  task automatic send(input logic [7:0] b);
    rx_data = b; rx_valid = 1; step(); rx_valid = 0;
  endtask
  task automatic push(input logic last, input logic [7:0] len, input logic [7:0] d);
    sb.push_back({last, len, d});
  endtask
  task automatic drain(input string name);
    for (int i = 0; i < 100 && (sb.size() != 0 || pkt_valid); i++) step();
    checks++;
    if (sb.size() != 0 || pkt_valid) $display("FAIL %s_drain got pending=%0d valid=%b expected 0 0", name, sb.size(), pkt_valid);
    else passes++;
  endtask
  task automatic test_reset();
    repeat (3) step();
    @(negedge clk);
    checks++;
    if ({pkt_valid, pkt_last, err_checksum, err_length, err_overrun, err_timeout, pkt_data, pkt_len} !== 22'd0)
      $display("FAIL reset_outputs got %h expected 0", {pkt_valid, pkt_last, err_checksum, err_length, err_overrun, err_timeout, pkt_data, pkt_len});
    else passes++;
    step(); reset = 0; step();
  endtask
  task automatic test_good();
    int c0 = n_chk + n_len + n_ovr + n_to;
    push(0, 3, 8'h11); push(0, 3, 8'h22); push(1, 3, 8'h33);
    send(8'hA5); send(8'h03); send(8'h11); send(8'h22); send(8'h33);
    checks++;
    if (pkt_valid !== 1'b0) $display("FAIL good_early_valid got %b expected 0", pkt_valid); else passes++;
    send(8'h69);
    checks++;
    if (pkt_valid !== 1'b1 || pkt_data !== 8'h11) $display("FAIL good_first_cycle got valid=%b data=%h expected 1 11", pkt_valid, pkt_data); else passes++;
    drain("good");
    checks++;
    if (n_chk + n_len + n_ovr + n_to !== c0) $display("FAIL good_errors got %0d expected %0d", n_chk + n_len + n_ovr + n_to, c0); else passes++;
  endtask
  task automatic test_checksum();
    int c0 = n_chk, v0 = n_valid;
    send(8'hA5); send(8'h03); send(8'h11); send(8'h22); send(8'h33); send(8'h00);
    repeat (5) step();
    checks++;
    if (n_chk - c0 !== 1) $display("FAIL checksum_pulse got %0d expected 1", n_chk - c0); else passes++;
    checks++;
    if (n_valid !== v0) $display("FAIL checksum_valid got %0d expected 0", n_valid - v0); else passes++;
  endtask
  task automatic test_length();
    int l0 = n_len;
    send(8'h00); send(8'hFF); send(8'hA5); send(8'h00);
    step();
    checks++;
    if (n_len - l0 !== 1) $display("FAIL length_zero got %0d expected 1", n_len - l0); else passes++;
    send(8'hA5); send(8'h11);
    step();
    checks++;
    if (n_len - l0 !== 2) $display("FAIL length_max got %0d expected 2", n_len - l0); else passes++;
    push(1, 1, 8'h7E);
    send(8'hA5); send(8'h01); send(8'h7E); send(8'h7F);
    drain("length");
  endtask
  task automatic test_backpressure();
    int o0 = n_ovr;
    pkt_ready = 0;
    push(0, 2, 8'hAA); push(1, 2, 8'hBB);
    send(8'hA5); send(8'h02); send(8'hAA); send(8'hBB); send(8'h67);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checks++;
      if (pkt_valid !== 1'b1 || pkt_data !== 8'hAA || pkt_last !== 1'b0 || pkt_len !== 8'd2)
        $display("FAIL hold_%0d got valid=%b data=%h last=%b len=%h expected 1 aa 0 02", i, pkt_valid, pkt_data, pkt_last, pkt_len);
      else passes++;
      step();
    end
    send(8'h11);
    checks++;
    if (n_ovr - o0 !== 1) $display("FAIL overrun_pulse got %0d expected 1", n_ovr - o0); else passes++;
    pkt_ready = 1;
    drain("backpressure");
  endtask
  task automatic test_reset_mid();
    send(8'hA5); send(8'h02); send(8'hAA);
    reset = 1; step(); reset = 0;
    push(1, 1, 8'h55);
    send(8'hA5); send(8'h01); send(8'h55); send(8'h56);
    drain("reset_mid");
    pkt_ready = 0;
    send(8'hA5); send(8'h01); send(8'h55); send(8'h56);
    reset = 1;
    @(negedge clk);
    checks++;
    if ({pkt_valid, pkt_last, pkt_data, pkt_len} !== 18'd0) $display("FAIL reset_emit got %h expected 0", {pkt_valid, pkt_last, pkt_data, pkt_len}); else passes++;
    step(); reset = 0; step();
    checks++;
    if (pkt_valid !== 1'b0) $display("FAIL reset_emit_after got %b expected 0", pkt_valid); else passes++;
    pkt_ready = 1;
  endtask
  task automatic test_timeout();
    int t0 = n_to;
    send(8'hA5);
    repeat (82) step();
`ifdef UART_PKT_TIMEOUT_EN
    checks++;
    if (n_to - t0 !== 1) $display("FAIL timeout_pulse got %0d expected 1", n_to - t0); else passes++;
    push(1, 1, 8'h55);
    send(8'hA5); send(8'h01); send(8'h55); send(8'h56);
`else
    checks++;
    if (n_to !== t0) $display("FAIL timeout_tied got %0d expected 0", n_to - t0); else passes++;
    push(1, 1, 8'h55);
    send(8'h01); send(8'h55); send(8'h56);
`endif
    drain("timeout");
  endtask
  initial begin
    test_reset();
    test_good();
    test_checksum();
    test_length();
    test_backpressure();
    test_reset_mid();
    test_timeout();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
